// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
//   owner_t     : which port currently holds the lock (none / port 0 / port 1)
//   DEF_*       : default address width, data width and burst limit
//   port_owner  : maps a port index to its owner_t encoding
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int unsigned DEF_A         = 8;
  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  function automatic owner_t port_owner(input logic port);
    return port ? OWN_P1 : OWN_P0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin grant with bounded lock hold.
//   req[1:0]  : per-port access requests
//   owner     : port currently holding the lock
//   last_gnt  : port granted most recently (ties go to the other one)
//   at_limit  : owner has used up its locked grants while contended
//   gnt[1:0]  : one-hot (or zero) grant, always a subset of req
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     owner,
  input  logic       last_gnt,
  input  logic       at_limit,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    // The lock only wins while the owner still requests and is either
    // uncontended or below its burst allowance.
    if (owner == OWN_P0 && req[0] && (!req[1] || !at_limit)) begin
      gnt = 2'b01;
    end else if (owner == OWN_P1 && req[1] && (!req[0] || !at_limit)) begin
      gnt = 2'b10;
    end else begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Port 0 is the core load/store path, port 1 the block-copy/DMA engine.
//   Clk, Reset           : rising-edge clock, async active-low reset
//   Req/We/Lock/Addr/Wdata (x2) : requester side access request
//   Gnt (x2)             : access performed this cycle (combinational)
//   Rvalid/Rdata (x2)    : registered read return, one cycle after grant
//   MemWriteEn/MemAddress/MemDataIn : memory command from the granted port
//   MemDataOut           : combinational memory read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned A        = DEF_A,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned MaxBurst = DEF_MAX_BURST
) (
  input  logic         Clk,
  input  logic         Reset,

  input  logic         Req0,
  input  logic         We0,
  input  logic         Lock0,
  input  logic [A-1:0] Addr0,
  input  logic [W-1:0] Wdata0,
  output logic         Gnt0,
  output logic         Rvalid0,
  output logic [W-1:0] Rdata0,

  input  logic         Req1,
  input  logic         We1,
  input  logic         Lock1,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] Wdata1,
  output logic         Gnt1,
  output logic         Rvalid1,
  output logic [W-1:0] Rdata1,

  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  // Counter needs to reach MaxBurst-1; keep at least one bit for MaxBurst=1.
  localparam int unsigned CW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MaxBurst - 1);

  owner_t        owner_q,     owner_d;
  logic          last_gnt_q,  last_gnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rvalid0_q,   rvalid0_d;
  logic          rvalid1_q,   rvalid1_d;
  logic [W-1:0]  rdata0_q,    rdata0_d;
  logic [W-1:0]  rdata1_q,    rdata1_d;

  logic          at_limit;
  logic [1:0]    pick_gnt;
  logic [1:0]    gnt;

  assign at_limit = (burst_cnt_q == BURST_LIMIT);

  rr_pick2 u_pick (
    .req      ({Req1, Req0}),
    .owner    (owner_q),
    .last_gnt (last_gnt_q),
    .at_limit (at_limit),
    .gnt      (pick_gnt)
  );

  // Grants are suppressed while reset is asserted so no write can commit
  // on an edge that falls inside the reset pulse.
  assign gnt  = Reset ? pick_gnt : '0;
  assign Gnt0 = gnt[0];
  assign Gnt1 = gnt[1];

  always_comb begin
    MemAddress = Addr0;
    MemDataIn  = Wdata0;
    MemWriteEn = 1'b0;
    if (gnt[1]) begin
      MemAddress = Addr1;
      MemDataIn  = Wdata1;
      MemWriteEn = We1;
    end else if (gnt[0]) begin
      MemWriteEn = We0;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = '0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    if (gnt[0]) begin
      last_gnt_d = 1'b0;
      owner_d    = Lock0 ? OWN_P0 : OWN_NONE;
      if (owner_q == port_owner(1'b0)) begin
        burst_cnt_d = at_limit ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
      if (!We0) begin
        rvalid0_d = 1'b1;
        rdata0_d  = MemDataOut;
      end
    end else if (gnt[1]) begin
      last_gnt_d = 1'b1;
      owner_d    = Lock1 ? OWN_P1 : OWN_NONE;
      if (owner_q == port_owner(1'b1)) begin
        burst_cnt_d = at_limit ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
      if (!We1) begin
        rvalid1_d = 1'b1;
        rdata1_d  = MemDataOut;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      owner_q     <= OWN_NONE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign Rvalid0 = rvalid0_q;
  assign Rvalid1 = rvalid1_q;
  assign Rdata0  = rdata0_q;
  assign Rdata1  = rdata1_q;

endmodule
